// File: rtl/seg7_scan_decoder.sv
// Readback decoder for a two-digit multiplexed active-low 7-segment bus.
// Captures each digit once stable, decodes it to hex and emits the byte over valid/ready.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_n,
  input  logic [1:0] dig_sel,
  output logic [7:0] out_data,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

  // Returns {error, nibble}; unknown patterns map to nibble 0 with error set.
  function automatic logic [NIB_W:0] decode(input logic [SEG_W-1:0] p);
    case (p)
      7'h40:   decode = {1'b0, 4'h0};
      7'h79:   decode = {1'b0, 4'h1};
      7'h24:   decode = {1'b0, 4'h2};
      7'h30:   decode = {1'b0, 4'h3};
      7'h19:   decode = {1'b0, 4'h4};
      7'h12:   decode = {1'b0, 4'h5};
      7'h02:   decode = {1'b0, 4'h6};
      7'h78:   decode = {1'b0, 4'h7};
      7'h00:   decode = {1'b0, 4'h8};
      7'h10:   decode = {1'b0, 4'h9};
      7'h08:   decode = {1'b0, 4'hA};
      7'h03:   decode = {1'b0, 4'hB};
      7'h46:   decode = {1'b0, 4'hC};
      7'h21:   decode = {1'b0, 4'hD};
      7'h06:   decode = {1'b0, 4'hE};
      7'h0E:   decode = {1'b0, 4'hF};
      default: decode = {1'b1, 4'h0};
    endcase
  endfunction

  logic [SEG_W-1:0] s_seg, p_seg;
  logic [SEL_W-1:0] s_sel, p_sel;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [NIB_W-1:0] hi_nib, lo_nib;
  logic             hi_err, lo_err;
  logic             hi_flag, lo_flag;

  logic             sel_legal_c;
  logic             same_c;
  logic             capture_c;
  logic             load_c;
  logic [NIB_W:0]   dec_c;

  always_comb begin
    sel_legal_c = (s_sel == 2'b01) || (s_sel == 2'b10);
    same_c      = ({s_sel, s_seg} == {p_sel, p_seg});
    dec_c       = decode(s_seg);
    capture_c   = (state == ST_SETTLE) && sel_legal_c && same_c &&
                  (cnt == CNT_W'(STABLE_CYCLES - 1));
    load_c      = hi_flag && lo_flag && (!out_valid || out_ready);
  end

  // Input sampling plus one-cycle history for the stability compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_seg <= '0;
      s_sel <= '0;
      p_seg <= '0;
      p_sel <= '0;
    end else begin
      s_seg <= seg_n;
      s_sel <= dig_sel;
      p_seg <= s_seg;
      p_sel <= s_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_WAIT;
      cnt   <= '0;
    end else if (!sel_legal_c) begin
      state <= ST_WAIT;
      cnt   <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          state <= ST_SETTLE;
          cnt   <= CNT_W'(1);
        end
        ST_SETTLE: begin
          if (!same_c) begin
            cnt <= CNT_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (capture_c) state <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (!same_c) begin
            state <= ST_SETTLE;
            cnt   <= CNT_W'(1);
          end
        end
        default: begin
          state <= ST_WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Slot storage; a capture in the loading cycle survives the flag clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_nib  <= '0;
      lo_nib  <= '0;
      hi_err  <= 1'b0;
      lo_err  <= 1'b0;
      hi_flag <= 1'b0;
      lo_flag <= 1'b0;
    end else begin
      if (capture_c && s_sel[1]) begin
        hi_nib <= dec_c[NIB_W-1:0];
        hi_err <= dec_c[NIB_W];
      end
      if (capture_c && s_sel[0]) begin
        lo_nib <= dec_c[NIB_W-1:0];
        lo_err <= dec_c[NIB_W];
      end
      hi_flag <= (capture_c && s_sel[1]) || (hi_flag && !load_c);
      lo_flag <= (capture_c && s_sel[0]) || (lo_flag && !load_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else if (load_c) begin
      out_data  <= {hi_nib, lo_nib};
      out_err   <= hi_err || lo_err;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with STABLE_CYCLES = 4.
module tb_seg7_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_n;
  logic [1:0] dig_sel;
  logic [7:0] out_data;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_n     (seg_n),
    .dig_sel   (dig_sel),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Drive a digit for n cycles; returns 1 time unit after the last edge.
  task automatic present(input logic [1:0] sel, input logic [6:0] seg, input int n);
    dig_sel = sel;
    seg_n   = seg;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && out_valid !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    seg_n     = 7'h12;
    dig_sel   = 2'b10;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out_err, out_data} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b err=%b data=%h want 0/0/00", out_valid, out_err, out_data);
    end
    rst     = 1'b0;
    dig_sel = 2'b00;
    present(2'b00, 7'h7F, 3);
  endtask

  // Hi=5, lo=F; byte must appear exactly on the sixth edge after lo starts.
  task automatic test_basic_latency;
    out_ready = 1'b1;
    present(2'b10, 7'h12, 6);
    dig_sel = 2'b01;
    seg_n   = 7'h0E;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== (e == 6)) begin
        n_fail++;
        $display("FAIL latency_valid edge %0d: got %b want %b", e, out_valid, (e == 6));
      end
    end
    n_cmp++;
    if (out_data !== 8'h5F || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_byte: got data=%h err=%b want 5f/0", out_data, out_err);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drop: got valid=%b want 0", out_valid);
    end
    present(2'b00, 7'h7F, 3);
  endtask

  // Lo digit held only 3 cycles must never be captured.
  task automatic test_short_hold;
    present(2'b01, 7'h40, 3);
    present(2'b00, 7'h7F, 5);
    dig_sel = 2'b10;
    seg_n   = 7'h12;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL short_hold cycle %0d: got valid=%b want 0", i, out_valid);
      end
    end
    present(2'b00, 7'h7F, 3);
  endtask

  // Hi slot holds a stale 5 from before; the invalid recapture must overwrite it.
  task automatic test_invalid_pattern;
    present(2'b10, 7'h7F, 6);
    present(2'b01, 7'h79, 6);
    wait_valid(10);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h01 || out_err !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_byte: got valid=%b data=%h err=%b want 1/01/1", out_valid, out_data, out_err);
    end
    present(2'b00, 7'h7F, 3);
  endtask

  task automatic test_decode_table;
    logic [7:0] exp;
    for (int k = 0; k < 8; k++) begin
      exp = {4'(2 * k), 4'(2 * k + 1)};
      present(2'b10, pat[2 * k], 6);
      present(2'b01, pat[2 * k + 1], 6);
      wait_valid(10);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp || out_err !== 1'b0) begin
        n_fail++;
        $display("FAIL decode_pair %0d: got valid=%b data=%h err=%b want 1/%h/0", k, out_valid, out_data, out_err, exp);
      end
    end
    present(2'b00, 7'h7F, 3);
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    present(2'b10, 7'h12, 6);
    present(2'b01, 7'h0E, 6);
    dig_sel = 2'b10;
    seg_n   = 7'h30;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        dig_sel = 2'b01;
        seg_n   = 7'h19;
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h5F || out_err !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold cycle %0d: got valid=%b data=%h err=%b want 1/5f/0", i, out_valid, out_data, out_err);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h34 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_byte: got valid=%b data=%h err=%b want 1/34/0", out_valid, out_data, out_err);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drop: got valid=%b want 0", out_valid);
    end
    present(2'b00, 7'h7F, 3);
  endtask

  // Illegal select mid-settle restarts the count from the end of the glitch.
  task automatic test_glitch;
    out_ready = 1'b1;
    present(2'b01, 7'h40, 6);
    present(2'b10, 7'h24, 2);
    present(2'b11, 7'h24, 1);
    dig_sel = 2'b10;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== (e == 6)) begin
        n_fail++;
        $display("FAIL glitch_valid edge %0d: got %b want %b", e, out_valid, (e == 6));
      end
    end
    n_cmp++;
    if (out_data !== 8'h20 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_byte: got data=%h err=%b want 20/0", out_data, out_err);
    end
    present(2'b00, 7'h7F, 3);
  endtask

  // Async reset between edges drops a pending byte and any set slot flag.
  task automatic test_reset_mid_handshake;
    out_ready = 1'b0;
    present(2'b10, 7'h7F, 6);
    present(2'b01, 7'h12, 6);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h05 || out_err !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_byte: got valid=%b data=%h err=%b want 1/05/1", out_valid, out_data, out_err);
    end
    present(2'b10, 7'h24, 6);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, out_err, out_data} !== 10'd0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b err=%b data=%h want 0/0/00", out_valid, out_err, out_data);
    end
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    present(2'b01, 7'h40, 8);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags_cleared: got valid=%b want 0", out_valid);
    end
    present(2'b00, 7'h7F, 2);
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_short_hold();
    test_invalid_pattern();
    test_decode_table();
    test_back_to_back();
    test_glitch();
    test_reset_mid_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-7-segment display driver.
- Watches a two-digit, time-multiplexed, active-low 7-segment bus and captures each digit's pattern once it is stable.
- Decodes each pattern back to its 4-bit hex nibble and delivers the 8-bit value through a valid/ready handshake.
- Used as a display readback checker and loopback source for the 8-bit RPN ALU board logic.

Parameters:
- STABLE_CYCLES, 4: number of consecutive identical samples required before a digit is captured. Legal range 2..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- seg_n  input  7  segment bus, active-low; bit0=a, bit1=b, …, bit6=g.
- dig_sel  input  2  digit strobes, active-high; bit0 = low digit, bit1 = high digit.
- out_data  output  8  decoded byte: {high nibble, low nibble}.
- out_err  output  1  at least one nibble of out_data came from an unrecognised pattern.
- out_valid  output  1  out_data and out_err are valid.
- out_ready  input  1  consumer accepts the byte.

Behaviour:
- **Reset.** Async rst clears everything: out_data=0, out_err=0, out_valid=0, both slot flags=0, stability counter=0, FSM=WAIT. Reset mid-handshake drops any pending byte.
- **Input register.** seg_n and dig_sel are registered once (s_seg, s_sel). All logic below uses the registered copies.
- **Legal select.** s_sel must be exactly one-hot (01 or 10). 00 and 11 are illegal.
- **Decode table** (active-low gfedcba, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - Any other pattern decodes to nibble 0 with a per-slot error bit set.
- **FSM states:**
  - WAIT: s_sel illegal; counter=0.
  - SETTLE: counting identical samples.
  - HELD: digit captured; waiting for the sample to change.
- **Transitions:**
  - WAIT -> SETTLE: on a legal s_sel; counter=1.
  - SETTLE, sample {s_sel,s_seg} equal to previous cycle: counter++. When counter reaches STABLE_CYCLES, capture the decoded nibble and error bit into the slot selected by s_sel, set that slot's flag, and go to HELD.
  - SETTLE or HELD, sample differs but s_sel still legal: go to SETTLE, counter=1.
  - Any state, s_sel illegal: go to WAIT, counter=0.
  - HELD, sample unchanged: stay. No re-capture.
- **Capture latency.** A digit presented stably from cycle t is captured at the edge ending cycle t+STABLE_CYCLES, including the input-register stage.
- **Slot overwrite.** A recapture into an already-flagged slot overwrites it; the latest value wins.
- **Byte assembly.** When both slot flags are set and out_valid=0 (or a transfer happens in that same cycle):
  - Next edge: out_data={hi,lo}, out_err = hi_err OR lo_err, out_valid=1, both flags cleared.
  - A capture landing in that same cycle is lost for the byte being loaded; it sets its flag after the clear.
- **Handshake.**
  - Transfer occurs when out_valid and out_ready are both 1.
  - After a transfer, out_valid falls next cycle unless a new pair is loaded that same edge, which gives back-to-back bytes.
  - While out_valid=1 and out_ready=0: out_data and out_err are held stable; slots keep refreshing.
- **Ready-only.** out_ready asserted while out_valid=0 has no effect.

Test Plan:
1. rst pulse mid-cycle with no clk edge -> all outputs 0 immediately.
2. dig_sel=10, seg_n=0x12 for 6 cycles, then dig_sel=01, seg_n=0x0E for 6 cycles; out_ready=1 -> out_valid=1, out_data=0x5F, out_err=0.
3. dig_sel=01, seg_n=0x40 held only 3 cycles (STABLE_CYCLES=4), then changed -> no capture; out_valid stays 0.
4. Captures of hi=0x7F (invalid) and lo=0x79 -> out_data=0x01, out_err=1.
5. Backpressure: out_ready=0 while byte 0x5F is valid; digits change to 3,4 -> out_data stays 0x5F until ready. Then raise out_ready -> next byte 0x34 appears back-to-back.
6. dig_sel=11 or 00 glitch inside a settle window -> counter restarts; capture delayed by a full STABLE_CYCLES after the glitch ends.
